lbdr_input_fifo: RTL and testbench

- Per-port router input buffer; sits directly upstream of the LBDR routing stage.
- Accepts flits from the link, stores up to DEPTH flits and presents the head flit to LBDR.
- The head flit is presented as empty, flit_id and dst_addr.
- Returns one credit per flit consumed and flags link-protocol violations (overflow, malformed packets).

---
 rtl/router_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 37 +++
 rtl/lbdr_input_fifo.sv | 134 +++++++++++++
 tb/tb_lbdr_input_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// router_pkg: flit field widths, flit-type encodings and the write-side packet state.
// Revision 1.0
`default_nettype none

package router_pkg;

  localparam int FLIT_ID_W = 3;
  localparam int ADDR_W    = 4;

  localparam logic [FLIT_ID_W-1:0] HEADER      = 3'b001;
  localparam logic [FLIT_ID_W-1:0] BODY        = 3'b010;
  localparam logic [FLIT_ID_W-1:0] TAIL        = 3'b100;
  localparam logic [FLIT_ID_W-1:0] HEADER_TAIL = 3'b101;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_t;

  function automatic logic is_header(input logic [FLIT_ID_W-1:0] id);
    return (id == HEADER) || (id == HEADER_TAIL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH flit storage, synchronous write, asynchronous head read
// plus a routing-field peek port used to precompute the next-cycle head. Revision 1.0
`default_nettype none

module fifo_mem
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PTR_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [PTR_W-1:0]      peek_addr,
  output logic [FLIT_ID_W-1:0]  peek_id,
  output logic [ADDR_W-1:0]     peek_dst
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign peek_id  = mem[peek_addr][DATA_WIDTH-1 -: FLIT_ID_W];
  assign peek_dst = mem[peek_addr][ADDR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/lbdr_input_fifo.sv
// lbdr_input_fifo: router input buffer feeding LBDR with head flit, credits and link error flags.
// Revision 1.0
`default_nettype none

module lbdr_input_fifo
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] flit_in,
  input  logic                  read_en,
  output logic                  empty,
  output logic [FLIT_ID_W-1:0]  flit_id,
  output logic [ADDR_W-1:0]     dst_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  credit_out,
  output logic                  full,
  output logic                  overflow_err,
  output logic                  proto_err
);

  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]     CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]     CNT_MAX = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]     wr_ptr, rd_ptr, peek_ptr;
  logic [PTR_W:0]       count, count_nxt;
  logic                 wr, pop, head_change;
  logic [FLIT_ID_W-1:0] in_id, peek_id, next_id;
  logic [ADDR_W-1:0]    peek_dst, next_dst;
  pkt_state_t           state, state_nxt;
  logic                 proto_viol;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign wr    = valid_in & (~full | read_en);
  assign pop   = read_en & ~empty;
  assign in_id = flit_in[DATA_WIDTH-1 -: FLIT_ID_W];

  always_comb begin
    count_nxt = count;
    if (wr && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (pop && !wr) begin
      count_nxt = count - CNT_ONE;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W)
  ) u_mem (
    .clk      (clk),
    .wr_en    (wr),
    .wr_addr  (wr_ptr),
    .wr_data  (flit_in),
    .rd_addr  (rd_ptr),
    .rd_data  (data_out),
    .peek_addr(peek_ptr),
    .peek_id  (peek_id),
    .peek_dst (peek_dst)
  );

  assign flit_id = data_out[DATA_WIDTH-1 -: FLIT_ID_W];

  // Next-cycle head: the incoming flit when it lands in the slot the head will occupy
  assign peek_ptr    = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  assign next_id     = (wr && (peek_ptr == wr_ptr)) ? in_id : peek_id;
  assign next_dst    = (wr && (peek_ptr == wr_ptr)) ? flit_in[ADDR_W-1:0] : peek_dst;
  assign head_change = (pop | (empty & wr)) & (count_nxt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      credit_out   <= 1'b0;
      dst_addr     <= '0;
      overflow_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      count      <= count_nxt;
      credit_out <= pop;
      if (head_change && is_header(next_id)) dst_addr <= next_dst;
      if (valid_in && full && !read_en) overflow_err <= 1'b1;
      if (proto_viol) proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (wr) begin
      case (state)
        IDLE:    if (in_id == HEADER) state_nxt = IN_PKT;
        IN_PKT: begin
          if (in_id == TAIL || in_id == HEADER_TAIL) state_nxt = IDLE;
          else if (in_id == HEADER)                  state_nxt = IN_PKT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A header arriving mid-packet restarts the packet, so only the flag is raised here
  always_comb begin
    proto_viol = 1'b0;
    if (wr) begin
      case (state)
        IDLE:    proto_viol = (in_id == BODY) || (in_id == TAIL);
        IN_PKT:  proto_viol = is_header(in_id);
        default: proto_viol = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lbdr_input_fifo.sv
// tb_lbdr_input_fifo: directed and random stimulus checked against a queue-based model.
// Revision 1.0
`default_nettype none

module tb_lbdr_input_fifo;
  import router_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] flit_in;
  logic          read_en;
  logic          empty, full, credit_out, overflow_err, proto_err;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic [DW-1:0] data_out;

  lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .flit_in     (flit_in),
    .read_en     (read_en),
    .empty       (empty),
    .flit_id     (flit_id),
    .dst_addr    (dst_addr),
    .data_out    (data_out),
    .credit_out  (credit_out),
    .full        (full),
    .overflow_err(overflow_err),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored flits with unique sequence numbers, packet state, flags
  bit [DW-1:0] mq[$];
  int          sq[$];
  int          seq_ctr  = 0;
  int          head_seq = -1;
  bit          m_in_pkt = 0;
  bit          m_ovf    = 0;
  bit          m_proto  = 0;
  bit          m_credit = 0;
  bit [3:0]    m_dst    = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".empty"},    DW'(empty),        DW'(mq.size() == 0));
    chk({tag, ".full"},     DW'(full),         DW'(mq.size() == DEPTH));
    chk({tag, ".credit"},   DW'(credit_out),   DW'(m_credit));
    chk({tag, ".dst"},      DW'(dst_addr),     DW'(m_dst));
    chk({tag, ".overflow"}, DW'(overflow_err), DW'(m_ovf));
    chk({tag, ".proto"},    DW'(proto_err),    DW'(m_proto));
    if (mq.size() > 0) begin
      chk({tag, ".flit_id"}, DW'(flit_id), DW'(mq[0][DW-1:DW-3]));
      chk({tag, ".data"},    data_out,     mq[0]);
    end
  endtask

  function automatic bit [DW-1:0] mk(input bit [2:0] t, input bit [3:0] d);
    bit [DW-1:0] r;
    r = $urandom;
    return {t, r[24:0], d};
  endfunction

  function automatic bit [2:0] rand_type();
    case ($urandom_range(0, 3))
      0:       return HEADER;
      1:       return BODY;
      2:       return TAIL;
      default: return HEADER_TAIL;
    endcase
  endfunction

  // Called at a negedge: drive inputs, advance the model, check after the next posedge
  task automatic step(input string tag, input bit v, input bit [DW-1:0] f, input bit r);
    bit       wr, pop;
    bit [2:0] t;
    valid_in = v;
    flit_in  = f;
    read_en  = r;
    pop = r && (mq.size() > 0);
    wr  = v && ((mq.size() < DEPTH) || r);
    if (v && (mq.size() == DEPTH) && !r) m_ovf = 1;
    if (pop) begin
      void'(mq.pop_front());
      void'(sq.pop_front());
    end
    if (wr) begin
      mq.push_back(f);
      sq.push_back(seq_ctr);
      seq_ctr++;
      t = f[DW-1:DW-3];
      if (!m_in_pkt) begin
        if (t == BODY || t == TAIL) m_proto = 1;
        m_in_pkt = (t == HEADER);
      end else begin
        if (t == HEADER || t == HEADER_TAIL) m_proto = 1;
        if (t != BODY) m_in_pkt = (t == HEADER);
      end
    end
    m_credit = pop;
    if (mq.size() > 0 && sq[0] != head_seq) begin
      head_seq = sq[0];
      if (mq[0][DW-1:DW-3] == HEADER || mq[0][DW-1:DW-3] == HEADER_TAIL) m_dst = mq[0][3:0];
    end
    @(posedge clk);
    @(negedge clk);
    valid_in = 0;
    read_en  = 0;
    check_all(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) step(tag, 0, '0, 1);
  endtask

  initial begin
    rst      = 1'b0;
    valid_in = 1'b0;
    read_en  = 1'b0;
    flit_in  = '0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b1;

    // Single packet, reads from the second cycle on
    step("pkt", 1, mk(HEADER, 4'hA), 0);
    step("pkt", 1, mk(BODY, 4'h3), 1);
    step("pkt", 1, mk(BODY, 4'h5), 1);
    step("pkt", 1, mk(TAIL, 4'h7), 1);
    drain("pkt_drain");
    chk("pkt.dst_final", DW'(dst_addr), 32'hA);

    // Fill, overflow, then write-with-pop while full
    for (int i = 0; i < DEPTH; i++) step("fill", 1, mk(HEADER_TAIL, 4'(i + 1)), 0);
    step("ovf", 1, mk(HEADER_TAIL, 4'hF), 0);
    step("full_wr_pop", 1, mk(HEADER_TAIL, 4'hE), 1);
    drain("fill_drain");

    // Stream of single-flit packets with pointer wrap-around
    for (int i = 0; i < 10; i++) step("wrap", 1, mk(HEADER_TAIL, 4'(i)), 1);
    drain("wrap_drain");

    // Protocol errors: BODY while idle, HEADER while in a packet
    step("proto_body", 1, mk(BODY, 4'h1), 0);
    step("proto_hdr", 1, mk(HEADER, 4'h2), 0);
    step("proto_hdr2", 1, mk(HEADER, 4'h6), 0);
    step("proto_tail", 1, mk(TAIL, 4'h0), 0);
    drain("proto_drain");

    // Asynchronous reset with three flits stored
    for (int i = 0; i < 3; i++) step("pre_rst", 1, mk(HEADER_TAIL, 4'(i + 8)), 0);
    #2 rst = 1'b0;
    #1;
    mq.delete();
    sq.delete();
    m_in_pkt = 0;
    m_ovf    = 0;
    m_proto  = 0;
    m_credit = 0;
    m_dst    = 0;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 1, mk(HEADER, 4'hC), 0);
    step("post_rst_rd", 0, '0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), mk(rand_type(), 4'($urandom)),
           ($urandom_range(0, 2) != 0));
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
